// File: rtl/flit_deframer.sv
// flit_deframer: receive end of the PU flit link.
//
// Consumes a HEAD / BODY* / TAIL flit stream. A HEAD whose payload[PW-1:0] matches my_port_i is
// accepted only while rx_en_i is high. Half-word payloads (low half first) are packed into
// DW-bit words and written from base_addr_i upward. Completion, length and protocol errors are
// reported. Every output is registered, so each response appears one cycle after its flit.
//
// Flow codes in flit_i[DW/2+1:DW/2]: 0 = idle, 1 = HEAD, 2 = BODY, 3 = TAIL.
//
// Optional feature macro: DEFRAMER_STATS_EN
//   defined   -> pkt_cnt_o / drop_cnt_o / err_cnt_o are 16-bit saturating event counters
//   undefined -> the three counters are tied to zero
//
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   flit_i        {flow[1:0], payload[DW/2-1:0]}
//   my_port_i     own port number, compared against HEAD payload[PW-1:0]
//   base_addr_i   start word address for each accepted packet
//   rx_en_i       accept matching packets when high (sampled at HEAD only)
//   wr_en_o       write strobe; wr_addr_o / wr_data_o / wr_be_o hold their last value otherwise
//   wr_be_o       half enables: [0] = low half, [1] = high half
//   busy_o        high while receiving a packet
//   done_o        1-cycle pulse on packet completion; rx_len_o = half-word count, held
//   err_o         1-cycle pulse on protocol error; err_code_o held
//                 (1 = orphan BODY/TAIL, 2 = HEAD inside packet, 3 = overflow)
//   pkt_cnt_o, drop_cnt_o, err_cnt_o   statistics

module flit_deframer #(
    parameter int unsigned DW    = 32,
    parameter int unsigned AW    = 8,
    parameter int unsigned PW    = 4,
    parameter int          MY_ID = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DW/2+1:0]   flit_i,
    input  logic [PW-1:0]     my_port_i,
    input  logic [AW-1:0]     base_addr_i,
    input  logic              rx_en_i,
    output logic              wr_en_o,
    output logic [AW-1:0]     wr_addr_o,
    output logic [DW-1:0]     wr_data_o,
    output logic [1:0]        wr_be_o,
    output logic              busy_o,
    output logic              done_o,
    output logic [AW:0]       rx_len_o,
    output logic              err_o,
    output logic [1:0]        err_code_o,
    output logic [15:0]       pkt_cnt_o,
    output logic [15:0]       drop_cnt_o,
    output logic [15:0]       err_cnt_o
);

    localparam int unsigned HW = DW / 2;

    localparam logic [1:0] FlowHead = 2'd1;
    localparam logic [1:0] FlowBody = 2'd2;
    localparam logic [1:0] FlowTail = 2'd3;

    localparam logic [1:0] ErrOrphan   = 2'd1;
    localparam logic [1:0] ErrHead     = 2'd2;
    localparam logic [1:0] ErrOverflow = 2'd3;

    localparam logic [AW:0] LenMax = {(AW + 1){1'b1}};

    // MY_ID only tags simulation messages elsewhere; it is range-checked here with the others.
    if ((DW % 2) != 0 || PW > DW / 2 || MY_ID < 0) begin : g_param_check
        $error("flit_deframer: illegal parameter combination");
    end

    typedef enum logic [1:0] {StIdle, StRecv, StDrop} state_e;

    state_e          state_q;
    logic [AW-1:0]   addr_q;
    logic [AW:0]     len_q;
    logic            half_q;
    logic            ovf_q;
    logic [HW-1:0]   hold_q;

    logic            wr_en_q;
    logic [AW-1:0]   wr_addr_q;
    logic [DW-1:0]   wr_data_q;
    logic [1:0]      wr_be_q;
    logic            done_q;
    logic [AW:0]     rx_len_q;
    logic            err_q;
    logic [1:0]      err_code_q;

    logic [1:0]      flow;
    logic [HW-1:0]   payload;
    logic            is_head, is_body, is_tail;
    logic            head_match;
    logic            evt_done, evt_drop, evt_err;
    logic [1:0]      err_code_d;

    assign flow    = flit_i[HW+1:HW];
    assign payload = flit_i[HW-1:0];
    assign is_head = (flow == FlowHead);
    assign is_body = (flow == FlowBody);
    assign is_tail = (flow == FlowTail);

    // A HEAD is judged the same way in every state.
    assign head_match = is_head && rx_en_i && (payload[PW-1:0] == my_port_i);
    assign evt_drop   = is_head && !head_match;
    assign evt_done   = (state_q == StRecv) && is_tail;

    always_comb begin
        evt_err    = 1'b0;
        err_code_d = 2'd0;
        case (state_q)
            StIdle: begin
                if (is_body || is_tail) begin
                    evt_err    = 1'b1;
                    err_code_d = ErrOrphan;
                end
            end
            StRecv: begin
                if (is_head) begin
                    evt_err    = 1'b1;
                    err_code_d = ErrHead;
                end else if (is_body && (len_q == LenMax) && !ovf_q) begin
                    // Reported once per packet; later excess BODY flits are dropped silently.
                    evt_err    = 1'b1;
                    err_code_d = ErrOverflow;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            addr_q     <= '0;
            len_q      <= '0;
            half_q     <= 1'b0;
            ovf_q      <= 1'b0;
            hold_q     <= '0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            wr_be_q    <= 2'b00;
            done_q     <= 1'b0;
            rx_len_q   <= '0;
            err_q      <= 1'b0;
            err_code_q <= 2'd0;
        end else begin
            wr_en_q <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= evt_err;
            if (evt_err) begin
                err_code_q <= err_code_d;
            end

            if (is_head) begin
                // A HEAD inside a packet aborts it: pending half discarded, no flush, no done.
                if (head_match) begin
                    state_q <= StRecv;
                    addr_q  <= base_addr_i;
                    len_q   <= '0;
                    half_q  <= 1'b0;
                    ovf_q   <= 1'b0;
                end else begin
                    state_q <= StDrop;
                end
            end else begin
                case (state_q)
                    StRecv: begin
                        if (is_body) begin
                            if (len_q == LenMax) begin
                                ovf_q <= 1'b1;
                            end else begin
                                len_q <= len_q + (AW + 1)'(1);
                                if (!half_q) begin
                                    hold_q <= payload;
                                    half_q <= 1'b1;
                                end else begin
                                    wr_en_q   <= 1'b1;
                                    wr_addr_q <= addr_q;
                                    wr_data_q <= {payload, hold_q};
                                    wr_be_q   <= 2'b11;
                                    addr_q    <= addr_q + AW'(1);
                                    half_q    <= 1'b0;
                                end
                            end
                        end else if (is_tail) begin
                            if (half_q) begin
                                wr_en_q   <= 1'b1;
                                wr_addr_q <= addr_q;
                                wr_data_q <= {{HW{1'b0}}, hold_q};
                                wr_be_q   <= 2'b01;
                            end
                            half_q   <= 1'b0;
                            done_q   <= 1'b1;
                            rx_len_q <= len_q;
                            state_q  <= StIdle;
                        end
                    end
                    StDrop: begin
                        if (is_tail) begin
                            state_q <= StIdle;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign wr_en_o    = wr_en_q;
    assign wr_addr_o  = wr_addr_q;
    assign wr_data_o  = wr_data_q;
    assign wr_be_o    = wr_be_q;
    assign busy_o     = (state_q == StRecv);
    assign done_o     = done_q;
    assign rx_len_o   = rx_len_q;
    assign err_o      = err_q;
    assign err_code_o = err_code_q;

`ifdef DEFRAMER_STATS_EN
    logic [15:0] pkt_cnt_q, drop_cnt_q, err_cnt_q;

    // Counters advance in the same cycle the matching pulse is registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pkt_cnt_q  <= '0;
            drop_cnt_q <= '0;
            err_cnt_q  <= '0;
        end else begin
            if (evt_done && (pkt_cnt_q != 16'hFFFF)) begin
                pkt_cnt_q <= pkt_cnt_q + 16'd1;
            end
            if (evt_drop && (drop_cnt_q != 16'hFFFF)) begin
                drop_cnt_q <= drop_cnt_q + 16'd1;
            end
            if (evt_err && (err_cnt_q != 16'hFFFF)) begin
                err_cnt_q <= err_cnt_q + 16'd1;
            end
        end
    end

    assign pkt_cnt_o  = pkt_cnt_q;
    assign drop_cnt_o = drop_cnt_q;
    assign err_cnt_o  = err_cnt_q;
`else
    assign pkt_cnt_o  = 16'd0;
    assign drop_cnt_o = 16'd0;
    assign err_cnt_o  = 16'd0;
`endif

endmodule

// File: tb/tb_flit_deframer.sv
// Directed bench for flit_deframer (DW=32, AW=8, PW=4). Flow codes: 1 HEAD, 2 BODY, 3 TAIL.

module tb_flit_deframer;

    localparam logic [1:0] HEAD = 2'd1;
    localparam logic [1:0] BODY = 2'd2;
    localparam logic [1:0] TAIL = 2'd3;

`ifdef DEFRAMER_STATS_EN
    localparam int STATS = 1;
`else
    localparam int STATS = 0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [17:0] flit = '0;
    logic [3:0]  my_port = 4'd2;
    logic [7:0]  base_addr = 8'h20;
    logic        rx_en = 1'b1;
    logic        wr_en;
    logic [7:0]  wr_addr;
    logic [31:0] wr_data;
    logic [1:0]  wr_be;
    logic        busy, done, err;
    logic [8:0]  rx_len;
    logic [1:0]  err_code;
    logic [15:0] pkt_cnt, drop_cnt, err_cnt;

    int total = 0;
    int passed = 0;
    int wr_count = 0;
    int done_count = 0;
    int err_count = 0;

    flit_deframer #(.DW(32), .AW(8), .PW(4), .MY_ID(0)) dut (
        .clk(clk), .rst(rst), .flit_i(flit), .my_port_i(my_port), .base_addr_i(base_addr),
        .rx_en_i(rx_en), .wr_en_o(wr_en), .wr_addr_o(wr_addr), .wr_data_o(wr_data),
        .wr_be_o(wr_be), .busy_o(busy), .done_o(done), .rx_len_o(rx_len), .err_o(err),
        .err_code_o(err_code), .pkt_cnt_o(pkt_cnt), .drop_cnt_o(drop_cnt), .err_cnt_o(err_cnt)
    );

    always #5 clk = ~clk;

    // Pulse counters, sampled mid-cycle.
    always @(negedge clk) begin
        if (wr_en === 1'b1) wr_count <= wr_count + 1;
        if (done === 1'b1) done_count <= done_count + 1;
        if (err === 1'b1) err_count <= err_count + 1;
    end

    // Present one flit for one rising edge; returns #1 after that edge.
    task automatic send(input logic [1:0] fl, input logic [15:0] pl);
        @(negedge clk);
        flit = {fl, pl};
        @(posedge clk);
        #1;
        flit = '0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        idle(2);
        total++; if (wr_en !== 1'b0) $display("FAIL reset_wr_en: got %0h want 0", wr_en); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %0h want 0", busy); else passed++;
        total++; if (rx_len !== 9'd0) $display("FAIL reset_rx_len: got %0h want 0", rx_len); else passed++;
        total++; if (wr_addr !== 8'd0) $display("FAIL reset_wr_addr: got %0h want 0", wr_addr); else passed++;
        total++; if (pkt_cnt !== 16'd0) $display("FAIL reset_pkt_cnt: got %0h want 0", pkt_cnt); else passed++;
        @(negedge clk);
        rst = 1'b0;
        idle(1);
    endtask

    task automatic test_two_halves;
        int w0;
        w0 = wr_count;
        send(HEAD, 16'h0002);
        total++; if (busy !== 1'b1) $display("FAIL t1_busy: got %0h want 1", busy); else passed++;
        send(BODY, 16'h1111);
        total++; if (wr_en !== 1'b0) $display("FAIL t1_no_early_wr: got %0h want 0", wr_en); else passed++;
        send(BODY, 16'h2222);
        total++; if (wr_en !== 1'b1) $display("FAIL t1_wr_en: got %0h want 1", wr_en); else passed++;
        total++; if (wr_addr !== 8'h20) $display("FAIL t1_wr_addr: got %0h want 20", wr_addr); else passed++;
        total++; if (wr_data !== 32'h22221111) $display("FAIL t1_wr_data: got %0h want 22221111", wr_data); else passed++;
        total++; if (wr_be !== 2'b11) $display("FAIL t1_wr_be: got %0h want 3", wr_be); else passed++;
        send(TAIL, 16'h0000);
        total++; if (done !== 1'b1) $display("FAIL t1_done: got %0h want 1", done); else passed++;
        total++; if (rx_len !== 9'd2) $display("FAIL t1_rx_len: got %0d want 2", rx_len); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL t1_busy_end: got %0h want 0", busy); else passed++;
        idle(1);
        total++; if (done !== 1'b0) $display("FAIL t1_done_pulse: got %0h want 0", done); else passed++;
        total++; if (wr_count - w0 !== 1) $display("FAIL t1_wr_count: got %0d want 1", wr_count - w0); else passed++;
    endtask

    task automatic test_odd_flush;
        send(HEAD, 16'h0002);
        send(BODY, 16'h000A);
        send(BODY, 16'h000B);
        total++; if (wr_data !== 32'h000B000A) $display("FAIL t2_wr_data0: got %0h want 000b000a", wr_data); else passed++;
        total++; if (wr_addr !== 8'h20) $display("FAIL t2_wr_addr0: got %0h want 20", wr_addr); else passed++;
        send(BODY, 16'h000C);
        send(TAIL, 16'h0000);
        total++; if (wr_en !== 1'b1) $display("FAIL t2_flush_en: got %0h want 1", wr_en); else passed++;
        total++; if (wr_addr !== 8'h21) $display("FAIL t2_flush_addr: got %0h want 21", wr_addr); else passed++;
        total++; if (wr_data !== 32'h0000000C) $display("FAIL t2_flush_data: got %0h want c", wr_data); else passed++;
        total++; if (wr_be !== 2'b01) $display("FAIL t2_flush_be: got %0h want 1", wr_be); else passed++;
        total++; if (rx_len !== 9'd3) $display("FAIL t2_rx_len: got %0d want 3", rx_len); else passed++;
        idle(1);
        total++; if (wr_addr !== 8'h21) $display("FAIL t2_addr_hold: got %0h want 21", wr_addr); else passed++;
    endtask

    task automatic test_drop;
        int w0, d0, e0;
        w0 = wr_count; d0 = done_count; e0 = err_count;
        send(HEAD, 16'h0001);
        total++; if (busy !== 1'b0) $display("FAIL t3_busy: got %0h want 0", busy); else passed++;
        send(BODY, 16'h1234);
        send(BODY, 16'h5678);
        send(TAIL, 16'h0000);
        idle(1);
        total++; if (drop_cnt !== 16'(STATS)) $display("FAIL t3_drop_cnt: got %0d want %0d", drop_cnt, STATS); else passed++;
        // Matching port but reception disabled.
        rx_en = 1'b0;
        send(HEAD, 16'h0002);
        rx_en = 1'b1;
        total++; if (busy !== 1'b0) $display("FAIL t3_rx_en_busy: got %0h want 0", busy); else passed++;
        send(BODY, 16'h9999);
        send(TAIL, 16'h0000);
        idle(1);
        total++; if (wr_count - w0 !== 0) $display("FAIL t3_no_wr: got %0d want 0", wr_count - w0); else passed++;
        total++; if (done_count - d0 !== 0) $display("FAIL t3_no_done: got %0d want 0", done_count - d0); else passed++;
        total++; if (err_count - e0 !== 0) $display("FAIL t3_no_err: got %0d want 0", err_count - e0); else passed++;
        total++; if (drop_cnt !== 16'(2 * STATS)) $display("FAIL t3_drop_cnt2: got %0d want %0d", drop_cnt, 2 * STATS); else passed++;
    endtask

    task automatic test_orphan;
        send(BODY, 16'h5555);
        total++; if (err !== 1'b1) $display("FAIL t4_err: got %0h want 1", err); else passed++;
        total++; if (err_code !== 2'd1) $display("FAIL t4_err_code: got %0d want 1", err_code); else passed++;
        total++; if (wr_en !== 1'b0) $display("FAIL t4_no_wr: got %0h want 0", wr_en); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL t4_busy: got %0h want 0", busy); else passed++;
        idle(1);
        total++; if (err !== 1'b0) $display("FAIL t4_err_pulse: got %0h want 0", err); else passed++;
        total++; if (err_code !== 2'd1) $display("FAIL t4_code_hold: got %0d want 1", err_code); else passed++;
        send(TAIL, 16'h0000);
        total++; if (err !== 1'b1) $display("FAIL t4_tail_err: got %0h want 1", err); else passed++;
    endtask

    task automatic test_head_abort;
        int w0, d0;
        w0 = wr_count; d0 = done_count;
        send(HEAD, 16'h0002);
        send(BODY, 16'h0001);
        send(HEAD, 16'h0002);
        total++; if (err !== 1'b1) $display("FAIL t5_err: got %0h want 1", err); else passed++;
        total++; if (err_code !== 2'd2) $display("FAIL t5_err_code: got %0d want 2", err_code); else passed++;
        total++; if (busy !== 1'b1) $display("FAIL t5_busy: got %0h want 1", busy); else passed++;
        total++; if (wr_en !== 1'b0) $display("FAIL t5_no_flush: got %0h want 0", wr_en); else passed++;
        send(BODY, 16'h0002);
        send(BODY, 16'h0003);
        total++; if (wr_addr !== 8'h20) $display("FAIL t5_wr_addr: got %0h want 20", wr_addr); else passed++;
        total++; if (wr_data !== 32'h00030002) $display("FAIL t5_wr_data: got %0h want 00030002", wr_data); else passed++;
        send(TAIL, 16'h0000);
        total++; if (rx_len !== 9'd2) $display("FAIL t5_rx_len: got %0d want 2", rx_len); else passed++;
        idle(1);
        total++; if (wr_count - w0 !== 1) $display("FAIL t5_wr_count: got %0d want 1", wr_count - w0); else passed++;
        total++; if (done_count - d0 !== 1) $display("FAIL t5_done_count: got %0d want 1", done_count - d0); else passed++;
    endtask

    // 511 BODY flits reach the length ceiling; the 512th raises one overflow error.
    task automatic test_overflow;
        int w0, e0;
        w0 = wr_count; e0 = err_count;
        send(HEAD, 16'h0002);
        for (int i = 1; i <= 511; i++) begin
            send(BODY, 16'(i));
            if (i == 510) begin
                total++; if (wr_addr !== 8'h1E) $display("FAIL ovf_wrap_addr: got %0h want 1e", wr_addr); else passed++;
                total++; if (wr_data !== 32'h01FE01FD) $display("FAIL ovf_last_word: got %0h want 01fe01fd", wr_data); else passed++;
            end
        end
        idle(1);
        total++; if (err_count - e0 !== 0) $display("FAIL ovf_no_early_err: got %0d want 0", err_count - e0); else passed++;
        send(BODY, 16'hAAAA);
        total++; if (err !== 1'b1) $display("FAIL ovf_err: got %0h want 1", err); else passed++;
        total++; if (err_code !== 2'd3) $display("FAIL ovf_err_code: got %0d want 3", err_code); else passed++;
        total++; if (wr_en !== 1'b0) $display("FAIL ovf_no_wr: got %0h want 0", wr_en); else passed++;
        send(BODY, 16'hBBBB);
        total++; if (err !== 1'b0) $display("FAIL ovf_err_once: got %0h want 0", err); else passed++;
        total++; if (busy !== 1'b1) $display("FAIL ovf_busy: got %0h want 1", busy); else passed++;
        send(TAIL, 16'h0000);
        total++; if (wr_addr !== 8'h1F) $display("FAIL ovf_flush_addr: got %0h want 1f", wr_addr); else passed++;
        total++; if (wr_data !== 32'h000001FF) $display("FAIL ovf_flush_data: got %0h want 1ff", wr_data); else passed++;
        total++; if (wr_be !== 2'b01) $display("FAIL ovf_flush_be: got %0h want 1", wr_be); else passed++;
        total++; if (done !== 1'b1) $display("FAIL ovf_done: got %0h want 1", done); else passed++;
        total++; if (rx_len !== 9'd511) $display("FAIL ovf_rx_len: got %0d want 511", rx_len); else passed++;
        idle(1);
        total++; if (wr_count - w0 !== 256) $display("FAIL ovf_wr_count: got %0d want 256", wr_count - w0); else passed++;
        // Totals so far: 4 packets, 2 drops, 4 errors (2 orphan, 1 head, 1 overflow).
        total++; if (pkt_cnt !== 16'(4 * STATS)) $display("FAIL stats_pkt: got %0d want %0d", pkt_cnt, 4 * STATS); else passed++;
        total++; if (err_cnt !== 16'(4 * STATS)) $display("FAIL stats_err: got %0d want %0d", err_cnt, 4 * STATS); else passed++;
    endtask

    task automatic test_reset_mid_packet;
        send(HEAD, 16'h0002);
        send(BODY, 16'h7777);
        total++; if (busy !== 1'b1) $display("FAIL t6_busy_pre: got %0h want 1", busy); else passed++;
        rst = 1'b1;
        #1;
        total++; if (busy !== 1'b0) $display("FAIL t6_busy: got %0h want 0", busy); else passed++;
        total++; if (rx_len !== 9'd0) $display("FAIL t6_rx_len: got %0d want 0", rx_len); else passed++;
        total++; if (wr_addr !== 8'd0) $display("FAIL t6_wr_addr: got %0h want 0", wr_addr); else passed++;
        total++; if (wr_data !== 32'd0) $display("FAIL t6_wr_data: got %0h want 0", wr_data); else passed++;
        total++; if (err_code !== 2'd0) $display("FAIL t6_err_code: got %0d want 0", err_code); else passed++;
        total++; if (drop_cnt !== 16'd0) $display("FAIL t6_drop_cnt: got %0d want 0", drop_cnt); else passed++;
        @(negedge clk);
        rst = 1'b0;
        send(HEAD, 16'h0002);
        send(BODY, 16'h00AA);
        send(BODY, 16'h00BB);
        total++; if (wr_addr !== 8'h20) $display("FAIL t6_restart_addr: got %0h want 20", wr_addr); else passed++;
        total++; if (wr_data !== 32'h00BB00AA) $display("FAIL t6_restart_data: got %0h want 00bb00aa", wr_data); else passed++;
        send(TAIL, 16'h0000);
        total++; if (rx_len !== 9'd2) $display("FAIL t6_rx_len_after: got %0d want 2", rx_len); else passed++;
        total++; if (pkt_cnt !== 16'(STATS)) $display("FAIL t6_pkt_cnt: got %0d want %0d", pkt_cnt, STATS); else passed++;
    endtask

    initial begin
        test_reset();
        test_two_halves();
        test_odd_flush();
        test_drop();
        test_orphan();
        test_head_abort();
        test_overflow();
        test_reset_mid_packet();
        idle(2);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
